// File: rtl/line_clear.sv
// line_clear: removes full rows from a locked Tetris playfield, compacts the
// rows above downward and reports the cleared-row count (optional score).
// Ports:
//   clk      - system clock
//   nRst_i   - synchronous active-low reset
//   start_i  - 1-cycle request, accepted only while idle
//   grid_i   - playfield snapshot [ROWS-1:0][COLS-1:0][CW-1:0], row 0 = top
//   busy_o   - high while an operation is in progress (state != IDLE)
//   done_o   - 1-cycle pulse; grid_o/lines_o hold the result
//   grid_o   - working buffer, final result from done_o until next start
//   lines_o  - rows cleared by the last operation
//   score_o  - accumulated score, present only with LINE_CLEAR_SCORE_EN
// Build option: define LINE_CLEAR_SCORE_EN to generate the score counter;
// otherwise score_o is tied to zero.
module line_clear #(
    parameter int ROWS = 21,
    parameter int COLS = 10,
    parameter int CW   = 3
) (
    input  logic                                 clk,
    input  logic                                 nRst_i,
    input  logic                                 start_i,
    input  logic [ROWS-1:0][COLS-1:0][CW-1:0]    grid_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [ROWS-1:0][COLS-1:0][CW-1:0]    grid_o,
    output logic [4:0]                           lines_o,
    output logic [15:0]                          score_o
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                              r_state;
    logic [ROWS-1:0][COLS-1:0][CW-1:0]   r_buf;
    logic [RW-1:0]                       r_row_ptr;
    logic [4:0]                          r_cnt;
    logic [4:0]                          r_lines;
    logic                                w_row_full;

    // A row is full when every cell carries a nonzero colour.
    always_comb begin
        w_row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (r_buf[r_row_ptr][c] == '0) begin
                w_row_full = 1'b0;
            end
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] r_score;
    logic [15:0] w_score_add;
    logic [16:0] w_score_sum;

    // The score is taken from the final count at the edge that enters DONE.
    always_comb begin
        w_score_add = 16'd0;
        case (r_cnt)
            5'd0:    w_score_add = 16'd0;
            5'd1:    w_score_add = 16'd40;
            5'd2:    w_score_add = 16'd100;
            5'd3:    w_score_add = 16'd300;
            default: w_score_add = 16'd1200;
        endcase
    end

    assign w_score_sum = {1'b0, r_score} + {1'b0, w_score_add};
    assign score_o     = r_score;
`else
    assign score_o     = 16'd0;
`endif

    always_ff @(posedge clk) begin
        if (!nRst_i) begin
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_row_ptr <= '0;
            r_cnt     <= '0;
            r_lines   <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            r_score   <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_buf     <= grid_i;
                        r_row_ptr <= RW'(ROWS - 1);
                        r_cnt     <= '0;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_row_full) begin
                        r_cnt   <= r_cnt + 5'd1;
                        r_state <= S_SHIFT;
                    end else if (r_row_ptr == '0) begin
                        r_lines <= r_cnt;
`ifdef LINE_CLEAR_SCORE_EN
                        r_score <= w_score_sum[16] ? 16'hFFFF
                                                   : w_score_sum[15:0];
`endif
                        r_state <= S_DONE;
                    end else begin
                        r_row_ptr <= r_row_ptr - RW'(1);
                    end
                end
                S_SHIFT: begin
                    // Drop every row at or above the cleared one by one
                    // position; row_ptr stays so the new row is re-checked.
                    for (int r = 1; r < ROWS; r++) begin
                        if (r <= int'(r_row_ptr)) begin
                            r_buf[r] <= r_buf[r-1];
                        end
                    end
                    r_buf[0] <= '0;
                    r_state  <= S_SCAN;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_DONE);
    assign grid_o  = r_buf;
    assign lines_o = r_lines;

endmodule
